execute_multiply: RTL and testbench
===================================

# execute_multiply

Iterative shift-add multiplier for the execute stage, serving MUL, one-operand IMUL and two/three-operand IMUL in 8/16/32-bit widths. It is the companion of the execute-stage divider and uses the same start/busy/one-time handshake with the execute pipeline. It produces the full double-width product and the CF/OF overflow indication. The execute stage writes back the result once `mult_busy` drops.

## Interface
Parameters: none.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- exe_reset  in  1  pipeline flush; aborts any operation
- exe_ready  in  1  instruction retiring from execute; clears completion flag
- exe_is_8bit  in  1  8-bit operand size
- exe_operand_16bit  in  1  16-bit operand size (when not 8-bit)
- exe_operand_32bit  in  1  32-bit operand size (when not 8-bit)
- exe_cmd  in  7  `CMD_MUL` / `CMD_IMUL` select multiply; others ignored
- exe_mult_two_op  in  1  1: multiplicand = dst (2/3-operand IMUL); 0: multiplicand = eax
- eax  in  32  accumulator
- dst  in  32  destination/immediate-source operand
- src  in  32  multiplier operand
- mult_busy  out  1  stall request; = mult_cmd && (counter != 0 || ~one_time)
- mult_result  out  64  product, width 2N, zero-extended above bit 2N-1
- mult_overflow  out  1  CF=OF value

## Operation
- mult_cmd = exe_cmd is `CMD_MUL` or `CMD_IMUL`; N = 8/16/32 by size.
- Operand A = low N bits of (exe_mult_two_op ? dst : eax); operand B = low N bits of src.
- Signed = (exe_cmd == `CMD_IMUL`). In signed mode both operands are sign-extended from bit N-1 and converted to magnitudes. neg = signA ^ signB, evaluated combinationally from the live inputs.
- Start: mult_cmd && counter==0 && ~one_time.
  - Load counter = N+1.
  - Load multiplicand reg (64b) = |A|, multiplier reg (32b) = |B|, product reg (64b) = 0.
- Working (counter > 1), each cycle:
  - If multiplier[0], product += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - Sets one_time.
- Final (counter == 1): counter -> 0; registers hold. They also hold while counter==0, because start is gated by one_time.
- one_time clears on rst_n low, exe_reset, or exe_ready. Priority: rst_n > exe_reset > exe_ready > set.
- mult_result = (neg ? -product : product) masked to 2N bits. Magnitudes are at most 2^(N-1) signed or 2^N-1 unsigned, so the product never exceeds 64 bits.
- mult_overflow:
  - MUL: result[2N-1:N] != 0.
  - IMUL: result[2N-1:N-1] is not all-equal, i.e. the high half is not the sign extension of the low half.
- Two-operand IMUL uses the same overflow rule; truncation to N bits is the writeback's job.
- Reset values: counter 0, one_time 0, product/multiplicand 0, multiplier 0. Therefore mult_result = 0 and mult_overflow = 0, and mult_busy = mult_cmd.

## Timing
- Cycle 0: start accepted. Cycles 1..N: work, counter N+1..2. Cycle N+1: counter 1. Cycle N+2: mult_busy = 0 and the result is valid.
- Latency start->busy low: N+2 cycles (10/18/34).
- The result stays stable from busy low until exe_ready. A new start is possible the cycle after exe_ready.
- exe_reset mid-operation: counter->0 and one_time->0 next edge. A pending mult_cmd restarts fresh on the following cycle.
- Inputs (operands, size, cmd) must be held stable from start through exe_ready. neg and the size/cmd masks are read combinationally at output time.
- Simultaneous exe_ready and a working cycle cannot occur, because the pipeline does not retire while busy.

## Configuration
- `MULT_RADIX4_EN` defined: 2 multiplier bits per cycle.
  - Per cycle, add {0, A, 2A, 3A}, shift multiplicand by 2 and multiplier by 2.
  - counter loaded with N/2+1; latency 6/10/18.
  - 3A is precomputed at start into a 64b register.
- Undefined: radix-2 as above, with no 3A register.
- Results and overflow are bit-identical in both builds.

## Test plan
- MUL 8-bit, eax=0x00FF, src=0xFF -> busy low at cycle 10, result=0xFE01, overflow=1.
- IMUL 8-bit, A=0x80, B=0x80 -> result=0x4000, overflow=1. IMUL 8-bit, A=0xFF, B=0x02 -> result=0xFFFE, overflow=0.
- IMUL 32-bit, eax=0x80000000, src=0x80000000 -> result=0x4000000000000000, overflow=1. MUL 32-bit, eax=0xFFFFFFFF, src=0xFFFFFFFF -> 0xFFFFFFFE00000001, latency 34 (18 with `MULT_RADIX4_EN`).
- Two-op IMUL 16-bit, dst=0x0100, src=0xFFFF -> result=0xFFFFFF00 (masked to 32b), overflow=0. MUL 16-bit, src=0 -> result 0, overflow 0.
- exe_reset asserted at cycle 5 of a 32-bit MUL -> counter 0 next cycle, busy stays high, restart completes 34 cycles later with a correct result. Back-to-back MULs separated by exe_ready -> both results correct.

Source files
------------

// File: rtl/execute_multiply.sv
// Iterative shift-add multiplier for the execute stage (MUL, IMUL in 8/16/32-bit widths).
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle instead of one.

`ifndef CMD_MUL
`define CMD_MUL  7'd52
`endif
`ifndef CMD_IMUL
`define CMD_IMUL 7'd53
`endif

module execute_multiply (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exe_reset,
   input  logic        exe_ready,
   input  logic        exe_is_8bit,
   input  logic        exe_operand_16bit,
   input  logic        exe_operand_32bit,
   input  logic [6:0]  exe_cmd,
   input  logic        exe_mult_two_op,
   input  logic [31:0] eax,
   input  logic [31:0] dst,
   input  logic [31:0] src,
   output logic        mult_busy,
   output logic [63:0] mult_result,
   output logic        mult_overflow
);

   logic [5:0]  r_counter;
   logic        r_one_time;
   logic [63:0] r_product;
   logic [63:0] r_multiplicand;
   logic [31:0] r_multiplier;

   logic        w_mult_cmd;
   logic        w_signed;
   logic        w_sz32;
   logic [5:0]  w_n;
   logic [5:0]  w_cnt_load;
   logic        w_start;
   logic        w_work;
   logic [31:0] w_a_src;
   logic [31:0] w_a_ext;
   logic [31:0] w_b_ext;
   logic        w_a_sign;
   logic        w_b_sign;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_neg;
   logic [63:0] w_prod_signed;
   logic [63:0] w_addend;
   logic [63:0] w_mcand_next;
   logic [31:0] w_mplier_next;

   assign w_mult_cmd = (exe_cmd == `CMD_MUL) || (exe_cmd == `CMD_IMUL);
   assign w_signed   = (exe_cmd == `CMD_IMUL);
   // 16-bit is the fallback size whenever neither 8- nor 32-bit is selected
   assign w_sz32     = ~exe_is_8bit & exe_operand_32bit;
   assign w_n        = exe_is_8bit ? 6'd8 : (w_sz32 ? 6'd32 : 6'd16);
   assign w_a_src    = exe_mult_two_op ? dst : eax;

   always_comb begin
      w_a_sign = 1'b0;
      w_b_sign = 1'b0;
      w_a_ext  = '0;
      w_b_ext  = '0;
      if (exe_is_8bit) begin
         w_a_sign = w_signed & w_a_src[7];
         w_b_sign = w_signed & src[7];
         w_a_ext  = {{24{w_a_sign}}, w_a_src[7:0]};
         w_b_ext  = {{24{w_b_sign}}, src[7:0]};
      end else if (w_sz32) begin
         w_a_sign = w_signed & w_a_src[31];
         w_b_sign = w_signed & src[31];
         w_a_ext  = w_a_src;
         w_b_ext  = src;
      end else begin
         w_a_sign = w_signed & w_a_src[15];
         w_b_sign = w_signed & src[15];
         w_a_ext  = {{16{w_a_sign}}, w_a_src[15:0]};
         w_b_ext  = {{16{w_b_sign}}, src[15:0]};
      end
   end

   assign w_a_mag = w_a_sign ? (~w_a_ext + 32'd1) : w_a_ext;
   assign w_b_mag = w_b_sign ? (~w_b_ext + 32'd1) : w_b_ext;
   assign w_neg   = w_a_sign ^ w_b_sign;

   assign w_start   = w_mult_cmd && (r_counter == 6'd0) && ~r_one_time;
   assign w_work    = (r_counter > 6'd1);
   assign mult_busy = w_mult_cmd && ((r_counter != 6'd0) || ~r_one_time);

`ifdef MULT_RADIX4_EN
   logic [63:0] r_mcand3;

   assign w_cnt_load = {1'b0, w_n[5:1]} + 6'd1;

   always_comb begin
      case (r_multiplier[1:0])
         2'd1:    w_addend = r_multiplicand;
         2'd2:    w_addend = {r_multiplicand[62:0], 1'b0};
         2'd3:    w_addend = r_mcand3;
         default: w_addend = '0;
      endcase
   end

   assign w_mcand_next  = {r_multiplicand[61:0], 2'b00};
   assign w_mplier_next = {2'b00, r_multiplier[31:2]};

   // 3A tracks the multiplicand so each digit picks its addend without an adder chain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand3 <= '0;
      end else if (!exe_reset) begin
         if (w_start)
            r_mcand3 <= {32'd0, w_a_mag} + {31'd0, w_a_mag, 1'b0};
         else if (w_work)
            r_mcand3 <= {r_mcand3[61:0], 2'b00};
      end
   end
`else
   assign w_cnt_load    = w_n + 6'd1;
   assign w_addend      = r_multiplier[0] ? r_multiplicand : 64'd0;
   assign w_mcand_next  = {r_multiplicand[62:0], 1'b0};
   assign w_mplier_next = {1'b0, r_multiplier[31:1]};
`endif

   // exe_ready is applied last so it overrides the working-cycle set of one_time
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_counter      <= '0;
         r_one_time     <= 1'b0;
         r_product      <= '0;
         r_multiplicand <= '0;
         r_multiplier   <= '0;
      end else if (exe_reset) begin
         r_counter  <= '0;
         r_one_time <= 1'b0;
      end else begin
         if (w_start) begin
            r_counter      <= w_cnt_load;
            r_product      <= '0;
            r_multiplicand <= {32'd0, w_a_mag};
            r_multiplier   <= w_b_mag;
         end else if (w_work) begin
            r_counter      <= r_counter - 6'd1;
            r_product      <= r_product + w_addend;
            r_multiplicand <= w_mcand_next;
            r_multiplier   <= w_mplier_next;
            r_one_time     <= 1'b1;
         end else if (r_counter == 6'd1) begin
            r_counter <= 6'd0;
         end
         if (exe_ready)
            r_one_time <= 1'b0;
      end
   end

   assign w_prod_signed = w_neg ? (~r_product + 64'd1) : r_product;

   // Signed overflow: high half plus the low-half sign bit must be all equal
   always_comb begin
      mult_result   = '0;
      mult_overflow = 1'b0;
      if (exe_is_8bit) begin
         mult_result   = {48'd0, w_prod_signed[15:0]};
         mult_overflow = w_signed ? ~(&w_prod_signed[15:7] || ~|w_prod_signed[15:7])
                                  : |w_prod_signed[15:8];
      end else if (w_sz32) begin
         mult_result   = w_prod_signed;
         mult_overflow = w_signed ? ~(&w_prod_signed[63:31] || ~|w_prod_signed[63:31])
                                  : |w_prod_signed[63:32];
      end else begin
         mult_result   = {32'd0, w_prod_signed[31:0]};
         mult_overflow = w_signed ? ~(&w_prod_signed[31:15] || ~|w_prod_signed[31:15])
                                  : |w_prod_signed[31:16];
      end
   end

endmodule

// File: tb/tb_execute_multiply.sv
// Randomized self-checking bench for execute_multiply against an arithmetic reference model.
// Honours MULT_RADIX4_EN for the expected latency.

`ifndef CMD_MUL
`define CMD_MUL  7'd52
`endif
`ifndef CMD_IMUL
`define CMD_IMUL 7'd53
`endif

module tb_execute_multiply;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exe_reset;
   logic        exe_ready;
   logic        exe_is_8bit;
   logic        exe_operand_16bit;
   logic        exe_operand_32bit;
   logic [6:0]  exe_cmd;
   logic        exe_mult_two_op;
   logic [31:0] eax;
   logic [31:0] dst;
   logic [31:0] src;
   logic        mult_busy;
   logic [63:0] mult_result;
   logic        mult_overflow;

   int checks = 0;
   int errors = 0;

   execute_multiply u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .exe_reset         (exe_reset),
      .exe_ready         (exe_ready),
      .exe_is_8bit       (exe_is_8bit),
      .exe_operand_16bit (exe_operand_16bit),
      .exe_operand_32bit (exe_operand_32bit),
      .exe_cmd           (exe_cmd),
      .exe_mult_two_op   (exe_mult_two_op),
      .eax               (eax),
      .dst               (dst),
      .src               (src),
      .mult_busy         (mult_busy),
      .mult_result       (mult_result),
      .mult_overflow     (mult_overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer multiply of the N-bit operands, overflow from range of the full product
   function automatic void model(input bit imul, input int n, input logic [31:0] ar,
                                 input logic [31:0] br, output logic [63:0] res,
                                 output logic ov);
      logic [63:0] au, bu, full, m2;
      longint      as_, bs_, ps, lim;
      au = 64'(ar) & ((64'd1 << n) - 64'd1);
      bu = 64'(br) & ((64'd1 << n) - 64'd1);
      if (imul) begin
         as_ = longint'(au);
         bs_ = longint'(bu);
         if (au[n-1]) as_ = as_ - (longint'(1) << n);
         if (bu[n-1]) bs_ = bs_ - (longint'(1) << n);
         ps   = as_ * bs_;
         lim  = longint'(1) << (n - 1);
         ov   = (ps < -lim) || (ps >= lim);
         full = 64'(ps);
      end else begin
         full = au * bu;
         ov   = (full >> n) != 64'd0;
      end
      m2  = (n == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
      res = full & m2;
   endfunction

   function automatic int exp_latency(input int n);
`ifdef MULT_RADIX4_EN
      return n / 2 + 2;
`else
      return n + 2;
`endif
   endfunction

   // Called #1 after a posedge with the multiplier idle; abort_at>0 pulses exe_reset mid-operation
   task automatic run_op(input string tag, input bit imul, input int size, input bit two_op,
                         input logic [31:0] ea, input logic [31:0] d, input logic [31:0] s,
                         input int abort_at);
      int          n;
      int          cyc;
      logic [63:0] exp_res;
      logic        exp_ov;
      n = (size == 0) ? 8 : ((size == 1) ? 16 : 32);
      exe_is_8bit       = (size == 0);
      exe_operand_16bit = (size == 1);
      exe_operand_32bit = (size == 2);
      exe_mult_two_op   = two_op;
      eax = ea;
      dst = d;
      src = s;
      exe_cmd = imul ? `CMD_IMUL : `CMD_MUL;
      model(imul, n, two_op ? d : ea, s, exp_res, exp_ov);
      #1;
      if (abort_at > 0) begin
         repeat (abort_at) @(posedge clk);
         #1;
         exe_reset = 1'b1;
         @(posedge clk);
         #1;
         exe_reset = 1'b0;
         check_val({tag, "_abort_busy"}, 64'(mult_busy), 64'd1);
      end
      cyc = 0;
      while (mult_busy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val({tag, "_lat"}, 64'(cyc), 64'(exp_latency(n)));
      check_val({tag, "_res"}, mult_result, exp_res);
      check_val({tag, "_ovf"}, 64'(mult_overflow), 64'(exp_ov));
      repeat (2) @(posedge clk);
      #1;
      check_val({tag, "_hold"}, {mult_result[62:0], mult_busy}, {exp_res[62:0], 1'b0});
      exe_ready = 1'b1;
      @(posedge clk);
      #1;
      exe_ready = 1'b0;
      exe_cmd   = 7'd0;
   endtask

   initial begin
      logic [31:0] ra, rd, rs;
      rst_n = 1'b0;
      exe_reset = 1'b0;
      exe_ready = 1'b0;
      exe_is_8bit = 1'b0;
      exe_operand_16bit = 1'b0;
      exe_operand_32bit = 1'b1;
      exe_cmd = 7'd0;
      exe_mult_two_op = 1'b0;
      eax = '0;
      dst = '0;
      src = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_result", mult_result, 64'd0);
      check_val("rst_ovf", 64'(mult_overflow), 64'd0);
      check_val("rst_busy_idle", 64'(mult_busy), 64'd0);
      exe_cmd = `CMD_MUL;
      #1;
      check_val("rst_busy_cmd", 64'(mult_busy), 64'd1);
      exe_cmd = 7'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul8_ff",      1'b0, 0, 1'b0, 32'h0000_00FF, 32'h0, 32'h0000_00FF, 0);
      run_op("imul8_80",     1'b1, 0, 1'b0, 32'h0000_0080, 32'h0, 32'h0000_0080, 0);
      run_op("imul8_ff02",   1'b1, 0, 1'b0, 32'h0000_00FF, 32'h0, 32'h0000_0002, 0);
      run_op("imul32_min",   1'b1, 2, 1'b0, 32'h8000_0000, 32'h0, 32'h8000_0000, 0);
      run_op("mul32_max",    1'b0, 2, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 0);
      run_op("imul16_2op",   1'b1, 1, 1'b1, 32'h1234_5678, 32'h0000_0100, 32'h0000_FFFF, 0);
      run_op("mul16_zero",   1'b0, 1, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0000_0000, 0);
      run_op("mul32_abort",  1'b0, 2, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 5);
      run_op("mul32_b2b",    1'b0, 2, 1'b0, 32'h0001_0003, 32'h0, 32'h0002_0005, 0);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rd = $urandom;
         rs = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8080_8080;
            1: rs = 32'hFFFF_FFFF;
            2: rd = 32'h0000_0000;
            default: ;
         endcase
         run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), ra, rd, rs, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
